serial_byte_tx: RTL

//  Parallel-to-serial byte transmitter feeding the 8-bit serial-in shift register.

---
 rtl/serial_byte_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serial_byte_tx.sv
// Parallel-to-serial byte transmitter with a one-entry hold buffer, shifting LSB-first with a bit strobe.
// Optional even-parity bit period after the data bits when the PARITY_EN macro is defined.
module serial_byte_tx #(
    parameter int DW  = 8,
    parameter int DIV = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          sdo,
    output logic          sen,
    output logic          par_stb,
    output logic          busy,
    output logic          done
);

    localparam int BW = $clog2(DW);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
`ifdef PARITY_EN
        , PAR = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [DW-1:0] hold_q;
    logic          hold_full_q;
    logic          load;
    logic          accept;

    // The hold buffer empties into the shifter on the same edge it can be refilled.
    assign load     = (state_q == IDLE) && hold_full_q;
    assign in_ready = !hold_full_q || load;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE) || hold_full_q;

`ifdef PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^hold_q;
        end
    end
`endif

    // NOTE: every register, including the data-only hold and shift registers, is reset so the
    // post-reset state is fully defined; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            hold_full_q <= accept || (hold_full_q && !load);
            if (accept) begin
                hold_q <= in_data;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sdo       = 1'b0;
        sen       = 1'b0;
        par_stb   = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d   = hold_q;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                sdo = shift_q[0];
                if (div_cnt_q == DIV_LAST) begin
                    sen       = 1'b1;
                    div_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef PARITY_EN
                        state_d = PAR;
`else
                        state_d = DONE;
`endif
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

`ifdef PARITY_EN
            PAR: begin
                sdo = parity_q;
                if (div_cnt_q == DIV_LAST) begin
                    par_stb   = 1'b1;
                    div_cnt_d = '0;
                    state_d   = DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
`endif

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            // Any encoding not listed above recovers to IDLE.
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
